// File: rtl/serial_and_accumulator_pkg.sv
// Shared types and width helpers for the serial AND accumulator.
package serial_and_pkg;

    typedef enum logic {ACCUM, HOLD} sa_state_t;

    // Width of an index into n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_and_accumulator_if.sv
// Bit-stream input and frame-result output handshakes of the serial AND accumulator.
interface serial_and_accumulator_if
    import serial_and_pkg::*;
#(
    parameter int FRAME_LEN = 8
);
    localparam int LEN_W = $clog2(FRAME_LEN + 1);
    localparam int IDX_W = clog2_min1(FRAME_LEN);

    logic             in_valid;
    logic             in_ready;
    logic             in_bit;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic             out_and;
    logic [LEN_W-1:0] out_len;
    logic [IDX_W-1:0] out_zero_idx;

    // master: producer of bits and consumer of results
    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, out_and, out_len, out_zero_idx
    );

    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, out_and, out_len, out_zero_idx
    );
endinterface

// File: rtl/serial_and_accumulator_mux2.sv
// 2:1 mux, used as the running-AND update element.
module serial_and_accumulator_mux2 (
    input  logic sel,
    input  logic d0,
    input  logic d1,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

// File: rtl/serial_and_accumulator.sv
// Reduces a serial bit stream to one AND result per frame, with length and
// first-zero index; valid/ready on both sides, result held until accepted.
module serial_and_accumulator
    import serial_and_pkg::*;
#(
    parameter int FRAME_LEN = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    serial_and_accumulator_if.slave   bus
);
    localparam int LEN_W = $clog2(FRAME_LEN + 1);
    localparam int IDX_W = clog2_min1(FRAME_LEN);
    localparam logic [IDX_W-1:0] CNT_MAX = IDX_W'(FRAME_LEN - 1);

    sa_state_t        state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             acc_q, acc_d;
    logic             zero_seen_q, zero_seen_d;
    logic [IDX_W-1:0] zero_idx_q, zero_idx_d;
    logic             out_valid_q, out_valid_d;
    logic             out_and_q, out_and_d;
    logic [LEN_W-1:0] out_len_q, out_len_d;
    logic [IDX_W-1:0] out_zero_idx_q, out_zero_idx_d;

    logic             xfer;
    logic             frame_end;
    logic             acc_seed;
    logic             acc_nxt;
    logic             zero_seen_nxt;
    logic [IDX_W-1:0] zero_idx_nxt;

    assign bus.in_ready     = (state_q == ACCUM);
    assign bus.out_valid    = out_valid_q;
    assign bus.out_and      = out_and_q;
    assign bus.out_len      = out_len_q;
    assign bus.out_zero_idx = out_zero_idx_q;

    assign xfer      = bus.in_valid && (state_q == ACCUM);
    assign frame_end = bus.in_last || (cnt_q == CNT_MAX);

    // First bit of a frame seeds the AND with 1 so it passes straight through.
    assign acc_seed = (cnt_q == '0) ? 1'b1 : acc_q;

    serial_and_accumulator_mux2 u_acc_mux (
        .sel (bus.in_bit),
        .d0  (1'b0),
        .d1  (acc_seed),
        .y   (acc_nxt)
    );

    assign zero_seen_nxt = zero_seen_q || !bus.in_bit;
    assign zero_idx_nxt  = (!bus.in_bit && !zero_seen_q) ? cnt_q : zero_idx_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        zero_seen_d    = zero_seen_q;
        zero_idx_d     = zero_idx_q;
        out_valid_d    = out_valid_q;
        out_and_d      = out_and_q;
        out_len_d      = out_len_q;
        out_zero_idx_d = out_zero_idx_q;

        if (xfer) begin
            acc_d       = acc_nxt;
            zero_seen_d = zero_seen_nxt;
            zero_idx_d  = zero_idx_nxt;
            if (frame_end) begin
                // Counter parks at the final index; HOLD exit clears it.
                out_and_d      = acc_nxt;
                out_len_d      = LEN_W'(cnt_q) + LEN_W'(1);
                out_zero_idx_d = zero_seen_nxt ? zero_idx_nxt : '0;
                out_valid_d    = 1'b1;
                state_d        = HOLD;
            end else begin
                cnt_d = cnt_q + IDX_W'(1);
            end
        end else if (state_q == HOLD && bus.out_ready) begin
            out_valid_d = 1'b0;
            cnt_d       = '0;
            zero_seen_d = 1'b0;
            state_d     = ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ACCUM;
            cnt_q          <= '0;
            acc_q          <= 1'b0;
            zero_seen_q    <= 1'b0;
            zero_idx_q     <= '0;
            out_valid_q    <= 1'b0;
            out_and_q      <= 1'b0;
            out_len_q      <= '0;
            out_zero_idx_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            zero_seen_q    <= zero_seen_d;
            zero_idx_q     <= zero_idx_d;
            out_valid_q    <= out_valid_d;
            out_and_q      <= out_and_d;
            out_len_q      <= out_len_d;
            out_zero_idx_q <= out_zero_idx_d;
        end
    end
endmodule

// File: tb/tb_serial_and_accumulator.sv
// Table, hand-written and random checks of serial_and_accumulator against a frame-level model.
module tb_serial_and_accumulator;
    localparam int FL = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_and_accumulator_if #(.FRAME_LEN(FL)) bus ();
    serial_and_accumulator_if #(.FRAME_LEN(1))  bus1 ();

    serial_and_accumulator #(.FRAME_LEN(FL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    serial_and_accumulator #(.FRAME_LEN(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int tests = 0;
    int fails = 0;

    // Frame-level model: bits collected so far, and the pending result.
    logic q_bits[$];
    bit   pend;
    bit   accepted;
    int   m_and, m_len, m_zi;

    typedef struct {
        logic [7:0] bits;
        int         n;
        bit         use_last;
        int         e_and;
        int         e_len;
        int         e_zi;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic v, input logic b, input logic l, input logic r);
        bus.in_valid  = v;
        bus.in_bit    = b;
        bus.in_last   = l;
        bus.out_ready = r;
        @(posedge clk);
        accepted = 0;
        if (pend) begin
            if (r) pend = 0;
        end else if (v) begin
            accepted = 1;
            q_bits.push_back(b);
            if (l || q_bits.size() == FL) begin
                m_and = 1;
                m_zi  = -1;
                m_len = q_bits.size();
                for (int i = 0; i < q_bits.size(); i++)
                    if (!q_bits[i]) begin
                        m_and = 0;
                        if (m_zi < 0) m_zi = i;
                    end
                if (m_zi < 0) m_zi = 0;
                pend = 1;
                q_bits.delete();
            end
        end
        #1;
        chk("in_ready", int'(bus.in_ready), int'(!pend));
        chk("out_valid", int'(bus.out_valid), int'(pend));
        if (pend) begin
            chk("out_and", int'(bus.out_and), m_and);
            chk("out_len", int'(bus.out_len), m_len);
            chk("out_zero_idx", int'(bus.out_zero_idx), m_zi);
        end
    endtask

    // Present each bit until it is taken; a stuck handshake counts as a failure.
    task automatic send_frame(input logic [7:0] bits, input int n, input bit use_last, input logic r);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            do begin
                tick(1'b1, bits[i], use_last && (i == n - 1), r);
                guard++;
            end while (!accepted && guard < 20);
            if (!accepted) chk("accept_timeout", 0, 1);
        end
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk("rst out_valid", int'(bus.out_valid), 0);
        chk("rst out_and", int'(bus.out_and), 0);
        chk("rst out_len", int'(bus.out_len), 0);
        chk("rst out_zero_idx", int'(bus.out_zero_idx), 0);
        chk("rst in_ready", int'(bus.in_ready), 1);
        #1;
        rst_n = 1'b1;
        q_bits.delete();
        pend = 0;
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{8'b1111_1111, 8, 0, 1, 8, 0};
        tbl[1] = '{8'b1110_1011, 8, 0, 0, 8, 2};
        tbl[2] = '{8'b0000_0101, 3, 1, 0, 3, 1};
        tbl[3] = '{8'b0000_0000, 1, 1, 0, 1, 0};
        tbl[4] = '{8'b0000_0000, 8, 0, 0, 8, 0};
        tbl[5] = '{8'b1111_1111, 8, 1, 1, 8, 0};
        tbl[6] = '{8'b0111_1111, 8, 0, 0, 8, 7};

        bus.in_valid = 0; bus.in_bit = 0; bus.in_last = 0; bus.out_ready = 0;
        bus1.in_valid = 0; bus1.in_bit = 0; bus1.in_last = 0; bus1.out_ready = 0;
        pend = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset out_and", int'(bus.out_and), 0);
        chk("reset out_len", int'(bus.out_len), 0);
        chk("reset out_zero_idx", int'(bus.out_zero_idx), 0);
        chk("reset in_ready", int'(bus.in_ready), 1);
        chk("reset fl1 out_valid", int'(bus1.out_valid), 0);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            send_frame(tbl[k].bits, tbl[k].n, tbl[k].use_last, 1'b1);
            chk($sformatf("tbl%0d out_valid", k), int'(bus.out_valid), 1);
            chk($sformatf("tbl%0d out_and", k), int'(bus.out_and), tbl[k].e_and);
            chk($sformatf("tbl%0d out_len", k), int'(bus.out_len), tbl[k].e_len);
            chk($sformatf("tbl%0d out_zero_idx", k), int'(bus.out_zero_idx), tbl[k].e_zi);
            tick(1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Result held with a bit waiting: nothing consumed until the result goes.
        send_frame(8'b0000_0111, 3, 1, 1'b0);
        repeat (5) tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("stall out_and", int'(bus.out_and), 1);
        chk("stall out_len", int'(bus.out_len), 3);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        chk("bubble no accept", int'(accepted), 0);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        chk("pending bit accepted", int'(accepted), 1);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        chk("after stall out_len", int'(bus.out_len), 2);
        chk("after stall out_zero_idx", int'(bus.out_zero_idx), 0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-frame, then mid-HOLD.
        send_frame(8'b0000_1011, 4, 0, 1'b1);
        reset_pulse();
        send_frame(8'b0000_0111, 3, 1, 1'b0);
        reset_pulse();
        send_frame(8'b1111_1111, 8, 0, 1'b1);
        chk("post-reset out_and", int'(bus.out_and), 1);
        chk("post-reset out_len", int'(bus.out_len), 8);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 400; i++)
            tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) != 0));
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // FRAME_LEN=1: every bit is a frame.
        bus1.out_ready = 1; bus1.in_valid = 1; bus1.in_bit = 0;
        @(posedge clk); #1;
        chk("fl1 r0 out_valid", int'(bus1.out_valid), 1);
        chk("fl1 r0 out_and", int'(bus1.out_and), 0);
        chk("fl1 r0 out_len", int'(bus1.out_len), 1);
        chk("fl1 r0 out_zero_idx", int'(bus1.out_zero_idx), 0);
        chk("fl1 r0 in_ready", int'(bus1.in_ready), 0);
        bus1.in_bit = 1;
        @(posedge clk); #1;
        chk("fl1 bubble out_valid", int'(bus1.out_valid), 0);
        chk("fl1 bubble in_ready", int'(bus1.in_ready), 1);
        @(posedge clk); #1;
        bus1.in_valid = 0;
        chk("fl1 r1 out_valid", int'(bus1.out_valid), 1);
        chk("fl1 r1 out_and", int'(bus1.out_and), 1);
        chk("fl1 r1 out_len", int'(bus1.out_len), 1);
        chk("fl1 r1 out_zero_idx", int'(bus1.out_zero_idx), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
